// File: rtl/gate_eval_pkg.sv
// rtl/gate_eval_pkg.sv - shared types and node-map helpers for the gate evaluation engine
package gate_eval_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOT  = 3'd3,
        OP_BUF  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_XNOR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Node address width of the default 20-in / 32-temp / 10-out configuration.
    localparam int DEF_NA_W = 6;

    typedef struct packed {
        op_e                 op;
        logic [DEF_NA_W-1:0] dst;
        logic [DEF_NA_W-1:0] src_a;
        logic [DEF_NA_W-1:0] src_b;
    } instr_t;

    function automatic int in_base();
        return 2;
    endfunction

    function automatic int tmp_base(input int in_w);
        return 2 + in_w;
    endfunction

    function automatic int out_base(input int in_w, input int tmp_n);
        return 2 + in_w + tmp_n;
    endfunction

endpackage

// File: rtl/gate_eval_alu.sv
// rtl/gate_eval_alu.sv - single two-input gate evaluator
module gate_eval_alu
    import gate_eval_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_BUF:  y = a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_eval_engine.sv
// rtl/gate_eval_engine.sv - sequential netlist evaluator, one gate instruction per cycle
module gate_eval_engine
    import gate_eval_pkg::*;
#(
    parameter  int IN_W       = 20,
    parameter  int OUT_W      = 10,
    parameter  int TMP_N      = 32,
    parameter  int PROG_DEPTH = 64,
    localparam int PA_W       = $clog2(PROG_DEPTH),
    localparam int NODE_N     = 2 + IN_W + TMP_N + OUT_W,
    localparam int NA_W       = $clog2(NODE_N),
    localparam int INSTR_W    = 3 + 3 * NA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prog_we,
    input  logic [PA_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [PA_W:0]      prog_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               busy,
    output logic               err_dst
);

    localparam int TB    = tmp_base(IN_W);
    localparam int WN    = TMP_N + OUT_W;
    localparam int PAD_N = 1 << NA_W;

    state_e             state;
    logic [INSTR_W-1:0] imem [PROG_DEPTH];
    logic [IN_W-1:0]    in_q;
    logic [WN-1:0]      wn;
    logic [PA_W-1:0]    pc;
    logic [PA_W:0]      len_q;
    logic [PA_W:0]      len_sat;

    logic [INSTR_W-1:0] ir;
    logic [2:0]         op;
    logic [NA_W-1:0]    dst, sa, sb;
    logic [PAD_N-1:0]   node_pad;
    logic [WN-1:0]      hit;
    logic               dst_ok, a, b, y, last;

    assign ir  = imem[pc];
    assign op  = ir[INSTR_W-1 -: 3];
    assign dst = ir[3*NA_W-1 -: NA_W];
    assign sa  = ir[2*NA_W-1 -: NA_W];
    assign sb  = ir[NA_W-1:0];

    // Addresses past the last node land in the zero padding.
    always_comb begin
        node_pad = '0;
        node_pad[NODE_N-1:0] = {wn, in_q, 2'b10};
    end

    assign a = node_pad[sa];
    assign b = node_pad[sb];

    always_comb begin
        hit = '0;
        for (int k = 0; k < WN; k++) begin
            hit[k] = (dst == NA_W'(TB + k));
        end
    end

    assign dst_ok   = |hit;
    assign last     = ({1'b0, pc} == len_q - 1'b1);
    assign len_sat  = (prog_len > (PA_W+1)'(PROG_DEPTH)) ? (PA_W+1)'(PROG_DEPTH) : prog_len;
    assign out_data = wn[TMP_N +: OUT_W];

    gate_eval_alu u_alu (
        .op (op),
        .a  (a),
        .b  (b),
        .y  (y)
    );

    // Program store is deliberately unreset so a loaded netlist survives reset.
    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE) begin
            imem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_q      <= '0;
            wn        <= '0;
            pc        <= '0;
            len_q     <= '0;
            err_dst   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_q     <= in_data;
                        len_q    <= len_sat;
                        wn       <= '0;
                        err_dst  <= 1'b0;
                        pc       <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (len_sat == '0) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < WN; k++) begin
                        if (hit[k]) wn[k] <= y;
                    end
                    if (!dst_ok) err_dst <= 1'b1;
                    pc <= pc + 1'b1;
                    if (last) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_eval_engine.sv
// tb/tb_gate_eval_engine.sv - self-checking bench for gate_eval_engine
module tb_gate_eval_engine;
    import gate_eval_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [20:0] prog_data = '0;
    logic [6:0]  prog_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_data;
    logic        busy;
    logic        err_dst;

    int tests = 0;
    int fails = 0;
    instr_t shadow [64];

    gate_eval_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .err_dst   (err_dst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic instr_t mk(input int op, input int d, input int sa, input int sb);
        instr_t t;
        t.op    = op_e'(op[2:0]);
        t.dst   = d[5:0];
        t.src_a = sa[5:0];
        t.src_b = sb[5:0];
        return t;
    endfunction

    // Reference: walk the program over an array of node values.
    function automatic void model(input int len, input logic [19:0] din,
                                  output logic [9:0] od, output logic er);
        bit nodes [64];
        int n;
        n = (len > 64) ? 64 : len;
        for (int k = 0; k < 64; k++) nodes[k] = 1'b0;
        nodes[1] = 1'b1;
        for (int k = 0; k < 20; k++) nodes[2 + k] = din[k];
        er = 1'b0;
        for (int i = 0; i < n; i++) begin
            bit va, vb, r;
            va = nodes[shadow[i].src_a];
            vb = nodes[shadow[i].src_b];
            case (shadow[i].op)
                OP_AND:  r = va & vb;
                OP_OR:   r = va | vb;
                OP_XOR:  r = va ^ vb;
                OP_NOT:  r = !va;
                OP_BUF:  r = va;
                OP_NAND: r = !(va & vb);
                OP_NOR:  r = !(va | vb);
                default: r = (va == vb);
            endcase
            if (shadow[i].dst >= 22) nodes[shadow[i].dst] = r;
            else er = 1'b1;
        end
        for (int k = 0; k < 10; k++) od[k] = nodes[54 + k];
    endfunction

    task automatic wr(input int addr, input instr_t d);
        prog_we   = 1'b1;
        prog_addr = addr[5:0];
        prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
        shadow[addr] = d;
    endtask

    task automatic run(input int len, input logic [19:0] din, input int hold, input logic pw,
                       output logic [9:0] od, output logic er, output int cyc);
        prog_we  = pw;
        in_valid = 1'b1;
        prog_len = len[6:0];
        in_data  = din;
        @(negedge clk);
        in_valid = 1'b0;
        prog_we  = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
        od = out_data;
        er = err_dst;
        chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_data", 32'(out_data), 32'(od));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("held_out_data", 32'(out_data), 32'(od));
    endtask

    typedef struct {
        int         op;
        logic [3:0] tt;
    } vec_t;

    initial begin
        vec_t tbl [8];
        logic [9:0]  od, eo;
        logic        er, ee;
        logic [19:0] din;
        logic [3:0]  tt;
        int          cyc, len;

        tbl[0] = '{0, 4'b1000};
        tbl[1] = '{1, 4'b1110};
        tbl[2] = '{2, 4'b0110};
        tbl[3] = '{3, 4'b0011};
        tbl[4] = '{4, 4'b1100};
        tbl[5] = '{5, 4'b0111};
        tbl[6] = '{6, 4'b0001};
        tbl[7] = '{7, 4'b1001};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_dst", 32'(err_dst), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Truth tables: out0 = op(in0, in1).
        for (int v = 0; v < 8; v++) begin
            wr(0, mk(tbl[v].op, 54, 2, 3));
            for (int ab = 0; ab < 4; ab++) begin
                din = 20'(((ab & 1) << 1) | (ab >> 1));
                tt  = tbl[v].tt;
                run(1, din, 0, 1'b0, od, er, cyc);
                chk($sformatf("tt_op%0d_ab%0d", tbl[v].op, ab), 32'(od), 32'(tt[ab]));
                chk("tt_cycles", 32'(cyc), 32'd2);
            end
        end

        // XOR/OR pair, with out_ready held off for 5 cycles.
        wr(0, mk(2, 22, 21, 21));
        wr(1, mk(1, 57, 21, 22));
        run(2, 20'h80000, 5, 1'b0, od, er, cyc);
        chk("xor_or_out", 32'(od), 32'h008);
        chk("xor_or_cycles", 32'(cyc), 32'd3);
        chk("xor_or_err", 32'(er), 32'd0);

        run(0, 20'hABCDE, 0, 1'b0, od, er, cyc);
        chk("len0_out", 32'(od), 32'h000);
        chk("len0_cycles", 32'(cyc), 32'd1);

        // Dependence chain through an output node.
        wr(0, mk(3, 58, 0, 0));
        wr(1, mk(1, 63, 58, 10));
        run(2, 20'h0, 0, 1'b0, od, er, cyc);
        chk("chain_out", 32'(od), 32'h210);

        // Illegal destination then recovery.
        wr(0, mk(4, 2, 0, 0));
        wr(1, mk(4, 54, 2, 0));
        run(2, 20'h1, 0, 1'b0, od, er, cyc);
        chk("illegal_dst_out", 32'(od), 32'h001);
        chk("illegal_dst_err", 32'(er), 32'd1);
        run(0, 20'h1, 0, 1'b0, od, er, cyc);
        chk("err_cleared", 32'(er), 32'd0);

        // Write coinciding with accept must land before RUN.
        wr(0, mk(3, 54, 2, 0));
        prog_addr = 6'd0;
        prog_data = mk(4, 54, 2, 0);
        shadow[0] = mk(4, 54, 2, 0);
        run(1, 20'h1, 0, 1'b1, od, er, cyc);
        chk("we_at_accept", 32'(od), 32'h001);

        // Writes during RUN and DONE are dropped.
        wr(1, mk(2, 55, 2, 3));
        wr(2, mk(1, 56, 3, 0));
        prog_addr = 6'd0;
        prog_data = mk(3, 54, 2, 0);
        in_valid  = 1'b1;
        prog_len  = 7'd3;
        in_data   = 20'h1;
        @(negedge clk);
        in_valid = 1'b0;
        prog_we  = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("we_run_out", 32'(out_data), 32'h003);
        @(negedge clk);
        prog_we   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        run(3, 20'h1, 0, 1'b0, od, er, cyc);
        chk("we_run_readback", 32'(od), 32'h003);

        // Reset in the middle of a 10-instruction run.
        for (int i = 0; i < 10; i++) wr(i, mk($urandom % 8, 22 + $urandom % 42, $urandom % 64, $urandom % 64));
        din = 20'($urandom);
        in_valid = 1'b1;
        prog_len = 7'd10;
        in_data  = din;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_err", 32'(err_dst), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(10, din, 0, 1'b0, od, er, cyc);
        model(10, din, eo, ee);
        chk("rerun_out", 32'(od), 32'(eo));
        chk("rerun_cycles", 32'(cyc), 32'd11);

        // Randomised programs against the reference, including saturation.
        for (int i = 0; i < 64; i++) begin
            int d;
            d = ($urandom % 10 == 0) ? int'($urandom % 22) : 22 + int'($urandom % 42);
            wr(i, mk($urandom % 8, d, $urandom % 64, $urandom % 64));
        end
        for (int it = 0; it < 32; it++) begin
            for (int j = 0; j < 4; j++) begin
                int d;
                d = ($urandom % 10 == 0) ? int'($urandom % 22) : 22 + int'($urandom % 42);
                wr($urandom % 64, mk($urandom % 8, d, $urandom % 64, $urandom % 64));
            end
            len = (it == 0) ? 127 : (it == 1) ? 64 : int'($urandom % 72);
            din = 20'($urandom);
            run(len, din, $urandom % 3, 1'b0, od, er, cyc);
            model(len, din, eo, ee);
            chk($sformatf("rand%0d_out", it), 32'(od), 32'(eo));
            chk($sformatf("rand%0d_err", it), 32'(er), 32'(ee));
            chk($sformatf("rand%0d_cyc", it), 32'(cyc), 32'(((len > 64) ? 64 : len) + 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
